// File: rtl/loom_clk_ctrl_pkg.sv
// Shared types and default widths for the loom run-control sequencer.
package loom_clk_ctrl_pkg;

    localparam int unsigned STEP_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 64;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } clk_state_e;

    typedef enum logic [1:0] {
        RSN_NONE       = 2'd0,
        RSN_HOST       = 2'd1,
        RSN_STEP_DONE  = 2'd2,
        RSN_BREAKPOINT = 2'd3
    } stop_reason_e;

endpackage

// File: rtl/loom_clk_ctrl.sv
// Run-control sequencer producing the registered clock enable for loom_clk_gate.
// Optional enabled-cycle counter built when LOOM_CLK_CTRL_CYCLE_CNT_EN is defined.
module loom_clk_ctrl
    import loom_clk_ctrl_pkg::*;
#(
    parameter int unsigned StepW    = STEP_W_DEF,
    parameter int unsigned CntW     = CNT_W_DEF,
    parameter bit          ResetRun = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_req_i,
    input  logic             stop_req_i,
    input  logic             step_req_i,
    input  logic [StepW-1:0] step_count_i,
    input  logic             bp_hit_i,
    input  logic             cnt_clr_i,
    output logic             ce_o,
    output logic [1:0]       state_o,
    output logic [1:0]       stop_reason_o,
    output logic [StepW-1:0] step_rem_o,
    output logic             done_o,
    output logic             req_err_o,
    output logic [CntW-1:0]  cycle_count_o
);

    localparam clk_state_e RST_STATE = ResetRun ? ST_RUNNING : ST_STOPPED;

    clk_state_e   state_q, state_d;
    stop_reason_e reason_q, reason_d;
    logic [StepW-1:0] rem_q, rem_d;
    logic ce_q, ce_d;
    logic done_q, done_d;
    logic err_q, err_d;

    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_STOPPED: begin
                // A pending bp/stop still outranks lower requests even though it does nothing here.
                if (!(bp_hit_i || stop_req_i)) begin
                    if (step_req_i) begin
                        if (step_count_i != '0) begin
                            state_d  = ST_STEPPING;
                            rem_d    = step_count_i;
                            reason_d = RSN_NONE;
                        end else begin
                            done_d   = 1'b1;
                            reason_d = RSN_STEP_DONE;
                        end
                    end else if (run_req_i) begin
                        state_d  = ST_RUNNING;
                        reason_d = RSN_NONE;
                    end
                end
            end
            ST_RUNNING: begin
                if (bp_hit_i) begin
                    state_d  = ST_STOPPED;
                    reason_d = RSN_BREAKPOINT;
                    done_d   = 1'b1;
                end else if (stop_req_i) begin
                    state_d  = ST_STOPPED;
                    reason_d = RSN_HOST;
                    done_d   = 1'b1;
                end else if (step_req_i) begin
                    err_d = 1'b1;
                end
            end
            ST_STEPPING: begin
                if (bp_hit_i || stop_req_i) begin
                    state_d  = ST_STOPPED;
                    reason_d = bp_hit_i ? RSN_BREAKPOINT : RSN_HOST;
                    rem_d    = '0;
                    done_d   = 1'b1;
                end else begin
                    err_d = step_req_i || run_req_i;
                    rem_d = rem_q - StepW'(1);
                    if (rem_q == StepW'(1)) begin
                        state_d  = ST_STOPPED;
                        reason_d = RSN_STEP_DONE;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_STOPPED;
        endcase
        ce_d = (state_d != ST_STOPPED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RST_STATE;
            reason_q <= RSN_NONE;
            rem_q    <= '0;
            ce_q     <= ResetRun;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
            rem_q    <= rem_d;
            ce_q     <= ce_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef LOOM_CLK_CTRL_CYCLE_CNT_EN
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (ce_q) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_count_o = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign cycle_count_o  = '0;
`endif

    assign ce_o          = ce_q;
    assign state_o       = state_q;
    assign stop_reason_o = reason_q;
    assign step_rem_o    = rem_q;
    assign done_o        = done_q;
    assign req_err_o     = err_q;

endmodule

// File: tb/tb_loom_clk_ctrl.sv
// Directed self-checking bench for loom_clk_ctrl; counter expectations follow LOOM_CLK_CTRL_CYCLE_CNT_EN.
module tb_loom_clk_ctrl;

    localparam int unsigned StepW = 32;
    localparam int unsigned CntW  = 64;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             run_req_i, stop_req_i, step_req_i, bp_hit_i, cnt_clr_i;
    logic [StepW-1:0] step_count_i;
    logic             ce_o, done_o, req_err_o;
    logic [1:0]       state_o, stop_reason_o;
    logic [StepW-1:0] step_rem_o;
    logic [CntW-1:0]  cycle_count_o;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    loom_clk_ctrl #(
        .StepW   (StepW),
        .CntW    (CntW),
        .ResetRun(1'b1)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .run_req_i    (run_req_i),
        .stop_req_i   (stop_req_i),
        .step_req_i   (step_req_i),
        .step_count_i (step_count_i),
        .bp_hit_i     (bp_hit_i),
        .cnt_clr_i    (cnt_clr_i),
        .ce_o         (ce_o),
        .state_o      (state_o),
        .stop_reason_o(stop_reason_o),
        .step_rem_o   (step_rem_o),
        .done_o       (done_o),
        .req_err_o    (req_err_o),
        .cycle_count_o(cycle_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        run_req_i    = 1'b0;
        stop_req_i   = 1'b0;
        step_req_i   = 1'b0;
        bp_hit_i     = 1'b0;
        cnt_clr_i    = 1'b0;
        step_count_i = '0;
    endtask

    function automatic logic [63:0] cnt_exp(input logic [63:0] v);
`ifdef LOOM_CLK_CTRL_CYCLE_CNT_EN
        return v;
`else
        return 64'd0 & v;
`endif
    endfunction

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        #12;
        check_eq("rst_state", 64'(state_o), 64'd1);
        check_eq("rst_ce", 64'(ce_o), 64'd1);
        check_eq("rst_reason", 64'(stop_reason_o), 64'd0);
        check_eq("rst_rem", 64'(step_rem_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_err", 64'(req_err_o), 64'd0);
        check_eq("rst_cnt", cycle_count_o, 64'd0);
        rst_ni = 1'b1;

        // free run for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("run_ce", 64'(ce_o), 64'd1);
        end
        check_eq("run_state", 64'(state_o), 64'd1);
        check_eq("run_cnt10", cycle_count_o, cnt_exp(64'd10));

        // bp and stop together: breakpoint wins
        bp_hit_i = 1'b1; stop_req_i = 1'b1;
        tick();
        idle_inputs();
        check_eq("bp_ce", 64'(ce_o), 64'd0);
        check_eq("bp_state", 64'(state_o), 64'd0);
        check_eq("bp_reason", 64'(stop_reason_o), 64'd3);
        check_eq("bp_done", 64'(done_o), 64'd1);
        check_eq("bp_cnt", cycle_count_o, cnt_exp(64'd11));
        tick();
        check_eq("bp_done_once", 64'(done_o), 64'd0);
        check_eq("bp_cnt_hold", cycle_count_o, cnt_exp(64'd11));

        // step of 5 from STOPPED
        step_req_i = 1'b1; step_count_i = 32'd5;
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            check_eq("s5_ce", 64'(ce_o), 64'd1);
            check_eq("s5_state", 64'(state_o), 64'd2);
            check_eq("s5_rem", 64'(step_rem_o), 64'(5 - i));
            check_eq("s5_done", 64'(done_o), 64'd0);
            tick();
        end
        check_eq("s5_end_ce", 64'(ce_o), 64'd0);
        check_eq("s5_end_done", 64'(done_o), 64'd1);
        check_eq("s5_end_reason", 64'(stop_reason_o), 64'd2);
        check_eq("s5_end_rem", 64'(step_rem_o), 64'd0);
        check_eq("s5_end_state", 64'(state_o), 64'd0);
        check_eq("s5_cnt", cycle_count_o, cnt_exp(64'd16));
        tick();
        check_eq("s5_done_once", 64'(done_o), 64'd0);

        // step of 100 aborted by host stop after 40 enabled cycles
        step_req_i = 1'b1; step_count_i = 32'd100;
        tick();
        idle_inputs();
        check_eq("s100_rem0", 64'(step_rem_o), 64'd100);
        for (int i = 0; i < 39; i++) tick();
        check_eq("s100_rem61", 64'(step_rem_o), 64'd61);
        stop_req_i = 1'b1;
        tick();
        idle_inputs();
        check_eq("abort_ce", 64'(ce_o), 64'd0);
        check_eq("abort_reason", 64'(stop_reason_o), 64'd1);
        check_eq("abort_rem", 64'(step_rem_o), 64'd0);
        check_eq("abort_done", 64'(done_o), 64'd1);
        check_eq("abort_cnt", cycle_count_o, cnt_exp(64'd56));

        // zero-length step while STOPPED
        tick();
        step_req_i = 1'b1; step_count_i = 32'd0;
        tick();
        idle_inputs();
        check_eq("s0_ce", 64'(ce_o), 64'd0);
        check_eq("s0_done", 64'(done_o), 64'd1);
        check_eq("s0_reason", 64'(stop_reason_o), 64'd2);
        check_eq("s0_state", 64'(state_o), 64'd0);
        check_eq("s0_cnt", cycle_count_o, cnt_exp(64'd56));
        tick();
        check_eq("s0_ce_after", 64'(ce_o), 64'd0);
        check_eq("s0_done_once", 64'(done_o), 64'd0);

        // run, then illegal step while RUNNING, then counter clear
        run_req_i = 1'b1;
        tick();
        idle_inputs();
        check_eq("run2_state", 64'(state_o), 64'd1);
        check_eq("run2_reason", 64'(stop_reason_o), 64'd0);
        step_req_i = 1'b1; step_count_i = 32'd7;
        tick();
        idle_inputs();
        check_eq("rerr_err", 64'(req_err_o), 64'd1);
        check_eq("rerr_ce", 64'(ce_o), 64'd1);
        check_eq("rerr_state", 64'(state_o), 64'd1);
        check_eq("rerr_cnt", cycle_count_o, cnt_exp(64'd57));
        tick();
        check_eq("rerr_once", 64'(req_err_o), 64'd0);
        cnt_clr_i = 1'b1;
        tick();
        idle_inputs();
        check_eq("clr_cnt", cycle_count_o, 64'd0);
        tick();
        check_eq("clr_cnt_inc", cycle_count_o, cnt_exp(64'd1));

        // illegal request while STEPPING: step continues
        stop_req_i = 1'b1;
        tick();
        idle_inputs();
        step_req_i = 1'b1; step_count_i = 32'd3;
        tick();
        idle_inputs();
        run_req_i = 1'b1;
        tick();
        idle_inputs();
        check_eq("serr_err", 64'(req_err_o), 64'd1);
        check_eq("serr_state", 64'(state_o), 64'd2);
        check_eq("serr_rem", 64'(step_rem_o), 64'd2);
        tick();
        check_eq("serr_rem1", 64'(step_rem_o), 64'd1);
        check_eq("serr_once", 64'(req_err_o), 64'd0);
        tick();
        check_eq("serr_done", 64'(done_o), 64'd1);
        check_eq("serr_reason", 64'(stop_reason_o), 64'd2);

        // asynchronous reset in the middle of a step
        step_req_i = 1'b1; step_count_i = 32'd10;
        tick();
        idle_inputs();
        tick();
        tick();
        check_eq("mid_rem", 64'(step_rem_o), 64'd8);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("mrst_state", 64'(state_o), 64'd1);
        check_eq("mrst_ce", 64'(ce_o), 64'd1);
        check_eq("mrst_rem", 64'(step_rem_o), 64'd0);
        check_eq("mrst_reason", 64'(stop_reason_o), 64'd0);
        check_eq("mrst_done", 64'(done_o), 64'd0);
        check_eq("mrst_cnt", cycle_count_o, 64'd0);
        tick();
        check_eq("mrst_done_held", 64'(done_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
